// File: rtl/adder8_res_accum.sv
`default_nettype none
// ============================================================================
// Module   : adder8_res_accum
// Purpose  : Frames and accumulates 9-bit unsigned results from an upstream
//            adder8. Up to ACC_LEN results are summed into an ACC_W-bit
//            saturating accumulator. The frame is then presented downstream
//            with its sum, beat count and a sticky saturation flag.
//
// Parameters
//   ACC_LEN   : results per frame (1..16)
//   ACC_W     : accumulator / out_sum width (9..16)
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   in_valid  in   1      in_res carries a valid result
//   in_res    in   9      unsigned adder8 result (bit 8 is the carry)
//   in_ready  out  1      a beat is accepted this cycle if in_valid is high
//   flush     in   1      close the current partial frame early
//   out_valid out  1      out_sum / out_count / out_ovf are valid
//   out_ready in   1      downstream consumes the presented frame
//   out_sum   out  ACC_W  saturated frame sum (0 when out_valid is low)
//   out_count out  5      beats in the frame (0 when out_valid is low)
//   out_ovf   out  1      saturation occurred in the frame (0 when idle)
//
// Revision : 1.0 - initial release
// ============================================================================
module adder8_res_accum #(
   parameter int ACC_LEN = 4,
   parameter int ACC_W   = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [8:0]       in_res,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [4:0]       out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam int           c_sum_w   = ACC_W + 1;
   localparam logic [4:0]   c_acc_len = 5'(ACC_LEN);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_next;
   logic             r_live;      // high once an edge has seen rst_n released
   logic [ACC_W-1:0] r_acc;
   logic [4:0]       r_cnt;
   logic             r_ovf;

   // ------------------------------------------------------------------------
   // Control strobes from the FSM
   // ------------------------------------------------------------------------
   logic             w_rdy;
   logic             w_accept;
   logic             w_load;      // first beat of a frame
   logic             w_add;       // subsequent beat of a frame
   logic             w_clear;     // frame consumed downstream

   // ------------------------------------------------------------------------
   // Saturating adder: one guard bit above the accumulator catches overflow.
   // ------------------------------------------------------------------------
   logic [ACC_W:0]   w_sum_wide;
   logic             w_sat;
   logic [ACC_W-1:0] w_acc_add;
   logic [4:0]       w_cnt_inc;

   assign w_sum_wide = {1'b0, r_acc} + c_sum_w'(in_res);
   assign w_sat      = w_sum_wide[ACC_W];
   assign w_acc_add  = w_sat ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
   assign w_cnt_inc  = r_cnt + 5'd1;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_live  <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and control outputs
   // in_ready is a function of state, reset and r_live only, never out_ready,
   // so HOLD always costs one bubble cycle before the next frame starts.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_rdy        = 1'b0;
      w_accept     = 1'b0;
      w_load       = 1'b0;
      w_add        = 1'b0;
      w_clear      = 1'b0;
      out_valid    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_rdy    = rst_n & r_live;
            w_accept = in_valid & w_rdy;
            // A lone flush with nothing held is ignored here.
            if (w_accept) begin
               w_load = 1'b1;
               if ((c_acc_len == 5'd1) || flush) begin
                  w_state_next = S_HOLD;
               end else begin
                  w_state_next = S_ACCUM;
               end
            end
         end

         S_ACCUM: begin
            w_rdy    = rst_n & r_live;
            w_accept = in_valid & w_rdy;
            if (w_accept) begin
               // A flush on the same edge still includes this beat.
               w_add = 1'b1;
               if ((w_cnt_inc == c_acc_len) || flush) begin
                  w_state_next = S_HOLD;
               end
            end else if (flush) begin
               w_state_next = S_HOLD;
            end
         end

         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_clear      = 1'b1;
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_clear      = 1'b1;
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign in_ready = w_rdy;

   // ------------------------------------------------------------------------
   // Accumulator, beat counter and sticky saturation flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= 5'd0;
         r_ovf <= 1'b0;
      end else if (w_clear) begin
         r_acc <= '0;
         r_cnt <= 5'd0;
         r_ovf <= 1'b0;
      end else if (w_load) begin
         // in_res is unsigned: zero-extend only.
         r_acc <= ACC_W'(in_res);
         r_cnt <= 5'd1;
         r_ovf <= 1'b0;
      end else if (w_add) begin
         r_acc <= w_acc_add;
         r_cnt <= w_cnt_inc;
         r_ovf <= r_ovf | w_sat;
      end
   end

   // ------------------------------------------------------------------------
   // Frame outputs read zero whenever no frame is presented.
   // ------------------------------------------------------------------------
   assign out_sum   = out_valid ? r_acc : '0;
   assign out_count = out_valid ? r_cnt : 5'd0;
   assign out_ovf   = out_valid & r_ovf;

endmodule
`default_nettype wire

// File: doc/adder8_res_accum.md
ADDER8_RES_ACCUM -- requirements
Module: adder8_res_accum

Interface
REQ-001 SHALL have parameter ACC_LEN, default 4: results per frame, legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 13: accumulator and out_sum width, legal range 9..16.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: in_res holds a valid 9-bit adder8 result.
REQ-006 SHALL have port in_res  input  9: unsigned sum from the upstream adder8 (res_8_ is the MSB).
REQ-007 SHALL have port in_ready  output  1: block accepts a beat this cycle.
REQ-008 SHALL have port flush  input  1: close the current frame early.
REQ-009 SHALL have port out_valid  output  1: out_sum, out_count and out_ovf are valid.
REQ-010 SHALL have port out_ready  input  1: downstream consumes the frame.
REQ-011 SHALL have port out_sum  output  ACC_W: accumulated frame sum.
REQ-012 SHALL have port out_count  output  5: number of beats in the frame.
REQ-013 SHALL have port out_ovf  output  1: saturation occurred in this frame.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE (no beats held), ACCUM (1..ACC_LEN-1 beats held), HOLD (frame presented).
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD; in_ready SHALL NOT depend combinationally on out_ready.
REQ-016 Accept SHALL be defined as in_valid && in_ready at a rising edge.
REQ-017 On accept in IDLE, the block SHALL set acc=in_res and cnt=1, then go to ACCUM, or to HOLD if ACC_LEN=1.
REQ-018 On accept in ACCUM, the block SHALL set acc=acc+in_res and cnt=cnt+1; if the new cnt equals ACC_LEN, it SHALL go to HOLD.
REQ-019 Width rule: addition SHALL be performed at ACC_W+1 bits; if the result exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and the sticky ovf flag SHALL be set for the frame.
REQ-020 flush in ACCUM SHALL move the FSM to HOLD with the current partial frame.
REQ-021 flush coincident with an accept SHALL include that beat before moving to HOLD.
REQ-022 flush in IDLE without an accept SHALL be ignored; flush in IDLE with an accept SHALL produce a 1-beat frame.
REQ-023 flush in HOLD SHALL be ignored.
REQ-024 Latency: out_valid SHALL rise on the cycle after the closing accept or flush edge.
REQ-025 In HOLD, out_valid SHALL be 1, and out_sum, out_count and out_ovf SHALL be held stable until out_ready=1.
REQ-026 On out_ready in HOLD, the FSM SHALL go to IDLE, clear acc, cnt and ovf, and drop out_valid on the next cycle; in_ready SHALL return to 1 in that cycle (one-cycle bubble between frames).
REQ-027 out_ready outside HOLD SHALL have no effect.
REQ-028 When out_valid=0, out_sum, out_count and out_ovf SHALL read 0.
REQ-029 in_res SHALL be treated as unsigned; no sign extension SHALL be applied.

Reset
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE and acc, cnt and ovf SHALL be cleared.
REQ-031 Reset values SHALL be: out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-032 Reset values SHALL be: in_ready=1 from the first edge after rst_n returns to 1; in_ready=0 during reset.
REQ-033 Reset mid-frame or in HOLD SHALL discard the partial or pending frame with no output beat.
REQ-034 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-035 The bench SHALL cover: ACC_LEN=4; beats 1,2,3,4 back-to-back, out_ready=1 -> one frame: out_sum=10, out_count=4, out_ovf=0; out_valid one cycle after the 4th accept.
REQ-036 The bench SHALL cover: ACC_LEN=4, ACC_W=13; four beats of 511 -> out_sum=2044, out_ovf=0.
REQ-037 The bench SHALL cover: ACC_LEN=4, ACC_W=10; four beats of 511 -> out_sum=1023, out_ovf=1.
REQ-038 The bench SHALL cover: beats 100,200, then flush with no beat -> out_sum=300, out_count=2; next: beat 7 with flush asserted in the same cycle -> out_sum=7, out_count=1.
REQ-039 The bench SHALL cover: frame complete with out_ready=0 for 5 cycles -> out_valid=1 and outputs stable, in_ready=0, in_valid pulses not accepted; then out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-040 The bench SHALL cover: 2 beats accepted, rst_n=0 for one cycle, then beats 5,5,5,5 -> single frame: out_sum=20, out_count=4, no output from the aborted frame.
